dct_transpose_buf: RTL and testbench



---
 rtl/dct_pkg.sv | 18 +
 rtl/dct_tbuf_bank.sv | 39 +++
 rtl/dct_transpose_buf.sv | 124 ++++++++++++
 tb/tb_dct_transpose_buf.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types, mode encodings and sizing helper for the DCT transpose buffer.
package dct_pkg;

    localparam int DCT_SIZE = 10;

    // One stored coefficient at the default element width.
    typedef logic signed [DCT_SIZE-1:0] dct_elem_t;

    // Per-block replay mode, captured with column 0 of each block.
    localparam logic TBUF_MODE_PASS      = 1'b0;
    localparam logic TBUF_MODE_TRANSPOSE = 1'b1;

    // Pointer width for an n-entry index; never narrower than one bit.
    function automatic int tbuf_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One N x N storage bank: a whole column is written per cycle, and the read
// side returns either row rrow (transpose) or column rrow (pass-through).
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int SIZE = 10,
    parameter int N    = 8,
    localparam int IW  = tbuf_idx_w(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IW-1:0]            wcol,
    input  logic [N-1:0][SIZE-1:0]   wdata,
    input  logic [IW-1:0]            rrow,
    input  logic                     mode,
    output logic [N-1:0][SIZE-1:0]   rdata
);

    // mem[col][row]
    logic [N-1:0][N-1:0][SIZE-1:0] mem;

    // Column write port; contents are only cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[wcol] <= wdata;
    end

    // Read mux: transpose picks element rrow of every column, pass-through
    // returns column rrow unchanged.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < N; j++)
            rdata[j] = (mode == TBUF_MODE_TRANSPOSE) ? mem[j][rrow] : mem[rrow][j];
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the DCT column and row passes.
// Columns fill one bank while the other bank replays its block as N vectors.
// Optional build macro DCT_TBUF_STALL_CNT_EN adds a saturating 16-bit count of
// upstream stall cycles on port stall_cnt.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int SIZE = 10,
    parameter int N    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [N-1:0][SIZE-1:0]   data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sob,
    output logic                     out_eob,
    output logic [N-1:0][SIZE-1:0]   data_out
`ifdef DCT_TBUF_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int            IW   = tbuf_idx_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]                    full;
    logic [1:0]                    mode;
    logic                          wbank;
    logic                          rbank;
    logic [IW-1:0]                 wcol;
    logic [IW-1:0]                 rrow;
    logic                          in_fire;
    logic                          out_fire;
    logic [1:0]                    bank_we;
    logic [1:0][N-1:0][SIZE-1:0]   bank_rd;

    // Handshake signals come from registered state only; a freed bank shows
    // up as in_ready on the following cycle.
    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_sob   = out_valid && (rrow == '0);
    assign out_eob   = out_valid && (rrow == LAST);
    assign data_out  = out_valid ? bank_rd[rbank] : '0;

    // clr blocks the write so a flushed cycle cannot leave a stray column.
    assign bank_we[0] = in_fire && !clr && !wbank;
    assign bank_we[1] = in_fire && !clr &&  wbank;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tbuf_bank #(.SIZE(SIZE), .N(N)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[b]),
            .wcol  (wcol),
            .wdata (data_in),
            .rrow  (rrow),
            .mode  (mode[b]),
            .rdata (bank_rd[b])
        );
    end

    // Bank pointers, fill flags and per-block mode. Set and clear of full
    // never hit the same bank: a write needs an empty bank, a read a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= '0;
            mode  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcol  <= '0;
            rrow  <= '0;
        end else if (clr) begin
            full  <= '0;
            mode  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcol  <= '0;
            rrow  <= '0;
        end else begin
            if (in_fire) begin
                if (wcol == '0)
                    mode[wbank] <= in_mode;
                if (wcol == LAST) begin
                    wcol        <= '0;
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end else begin
                    wcol <= wcol + 1'b1;
                end
            end
            if (out_fire) begin
                if (rrow == LAST) begin
                    rrow        <= '0;
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end else begin
                    rrow <= rrow + 1'b1;
                end
            end
        end
    end

`ifdef DCT_TBUF_STALL_CNT_EN
    // Saturating count of cycles where upstream offers a column and is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (clr)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf (N=8, SIZE=10). Column c of a block
// with offset off carries element r = off + 10*r + c.
module tb_dct_transpose_buf;

    localparam int SIZE = 10;
    localparam int N    = 8;

    typedef logic [N-1:0][SIZE-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic out_ready = 1'b0;
    vec_t data_in = '0;
    logic in_ready, out_valid, out_sob, out_eob;
    vec_t data_out;
`ifdef DCT_TBUF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int   blk_off [4];
    logic blk_md  [4];

    always #5 clk = ~clk;

    dct_transpose_buf #(.SIZE(SIZE), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .data_out  (data_out)
`ifdef DCT_TBUF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk1(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, req);
        end
    endtask

    task automatic chkv(input string tag, input vec_t obs, input vec_t req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    function automatic vec_t col_vec(input int off, input int c);
        vec_t v;
        for (int r = 0; r < N; r++)
            v[r] = SIZE'(off + 10 * r + c);
        return v;
    endfunction

    // Output vector k: transpose gives row k across columns, pass gives column k.
    function automatic vec_t exp_vec(input int off, input logic md, input int k);
        vec_t v;
        for (int j = 0; j < N; j++)
            v[j] = md ? SIZE'(off + 10 * k + j) : SIZE'(off + 10 * j + k);
        return v;
    endfunction

    // Streams nblk blocks from blk_off/blk_md and scores every output vector.
    // rmode: 0 = out_ready always 1, 1 = random, 2 = held low for 20 cycles.
    task automatic run_stream(input int nblk, input int rmode, input string tag);
        int in_cnt = 0;
        int out_cnt = 0;
        int cyc = 0;
        int first_out = -1;
        logic in_fire, out_fire;
        while (out_cnt < nblk * N && cyc < 2000) begin
            if (in_cnt < nblk * N) begin
                in_valid = 1'b1;
                data_in  = col_vec(blk_off[in_cnt / N], in_cnt % N);
                in_mode  = blk_md[in_cnt / N];
            end else begin
                in_valid = 1'b0;
                data_in  = '0;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 20);
            endcase
            if (rmode == 2 && cyc == 20) begin
                chk1({tag, " in_ready both full"}, in_ready, 1'b0);
                chki({tag, " accepted before stall"}, in_cnt, 2 * N);
                chk1({tag, " out_valid held"}, out_valid, 1'b1);
                chk1({tag, " sob held"}, out_sob, 1'b1);
`ifdef DCT_TBUF_STALL_CNT_EN
                chki({tag, " stall_cnt"}, int'(stall_cnt), 4);
`endif
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_valid && first_out < 0)
                first_out = cyc;
            if (!out_valid)
                chkv({tag, " idle data_out"}, data_out, '0);
            if (out_fire) begin
                chkv({tag, " data"}, data_out,
                     exp_vec(blk_off[out_cnt / N], blk_md[out_cnt / N], out_cnt % N));
                chk1({tag, " sob"}, out_sob, (out_cnt % N) == 0);
                chk1({tag, " eob"}, out_eob, (out_cnt % N) == N - 1);
                out_cnt++;
            end
            @(posedge clk); #1;
            if (in_fire)
                in_cnt++;
            cyc++;
        end
        chki({tag, " vector count"}, out_cnt, nblk * N);
        if (rmode == 0)
            chki({tag, " first row latency"}, first_out, N);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
    endtask

    // Offers ncol columns of a block with out_ready low, checking acceptance.
    task automatic push_cols(input int off, input logic md, input int ncol, input string tag);
        for (int c = 0; c < ncol; c++) begin
            in_valid = 1'b1;
            in_mode  = md;
            data_in  = col_vec(off, c);
            chk1({tag, " in_ready"}, in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset out_valid", out_valid, 1'b0);
        chk1("reset out_sob", out_sob, 1'b0);
        chk1("reset out_eob", out_eob, 1'b0);
        chkv("reset data_out", data_out, '0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("idle out_valid", out_valid, 1'b0);
        out_ready = 1'b0;

        // Transpose, row 0 = {0..7}, row 7 = {70..77}
        blk_off[0] = 0;   blk_md[0] = 1'b1;
        run_stream(1, 0, "xpose");

        // Pass-through of the same data
        blk_off[0] = 0;   blk_md[0] = 1'b0;
        run_stream(1, 0, "pass");

        // Back-pressure across three blocks
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        blk_off[0] = 0;    blk_md[0] = 1'b1;
        blk_off[1] = 100;  blk_md[1] = 1'b0;
        blk_off[2] = -300; blk_md[2] = 1'b1;
        run_stream(3, 2, "bp");

        // Mixed modes with random downstream readiness
        blk_off[0] = 50;   blk_md[0] = 1'b1;
        blk_off[1] = -200; blk_md[1] = 1'b0;
        blk_off[2] = 120;  blk_md[2] = 1'b1;
        blk_off[3] = -5;   blk_md[3] = 1'b0;
        run_stream(4, 1, "mixed");

        // clr after five columns discards the partial block
        push_cols(30, 1'b1, 5, "clr part");
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk1("clr in_ready", in_ready, 1'b1);
        chk1("clr out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk1("clr no output", out_valid, 1'b0);
        out_ready = 1'b0;
        blk_off[0] = 7;   blk_md[0] = 1'b1;
        run_stream(1, 0, "after clr");

        // Async reset in the middle of replay
        push_cols(200, 1'b0, N, "rst fill");
        chk1("rst pre out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        chk1("rst mid out_valid", out_valid, 1'b1);
        chk1("rst mid sob", out_sob, 1'b0);
        chkv("rst mid data", data_out, exp_vec(200, 1'b0, 3));
        #2 rst = 1'b1;
        #1;
        chk1("rst async out_valid", out_valid, 1'b0);
        chkv("rst async data_out", data_out, '0);
        chk1("rst async in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        blk_off[0] = -100; blk_md[0] = 1'b0;
        run_stream(1, 0, "after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
